onchip_mem_arbiter: RTL and testbench

- Two-requester round-robin arbiter that shares one single-port on-chip RAM (4 x 32-bit, byte-enabled, registered address, unregistered q) between the NIOS data master (port m0) and the sprite/frame fetch engine (port m1).
- Presents an Avalon-MM slave with waitrequest/readdatavalid to each requester and drives the RAM's s1-style slave interface.
- Tracks read latency so every returned word is steered to the requester that issued it.

---
 rtl/onchip_mem_arbiter.sv | 173 +++++++++++++++++
 tb/tb_onchip_mem_arbiter.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/onchip_mem_arbiter.sv
// onchip_mem_arbiter
// Two-port round-robin arbiter in front of a single-port on-chip RAM.
// Port m0 is the NIOS data master and port m1 is the sprite/frame fetch engine.
// Each port sees an Avalon-MM slave with waitrequest and readdatavalid.
// Read returns are tracked through a small {valid, owner} pipeline, so that
// every word coming back from the RAM is steered to the port that asked for it.
// READ_LATENCY must be set to the RAM's address-to-q latency (1..4).

module onchip_mem_arbiter #(
    parameter int ADDR_W       = 2,
    parameter int DATA_W       = 32,
    parameter int BE_W         = 4,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,

    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,

    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,

    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata
);

    logic m0_req;
    logic m1_req;
    logic gnt_valid;
    logic gnt_id;
    logic gnt_write;
    logic gnt_read;

    logic last_gnt_d;
    logic last_gnt_q;

    logic [READ_LATENCY-1:0] rd_valid_d;
    logic [READ_LATENCY-1:0] rd_valid_q;
    logic [READ_LATENCY-1:0] rd_owner_d;
    logic [READ_LATENCY-1:0] rd_owner_q;

    logic ret_valid;
    logic ret_owner;

    // A port is requesting when it asks for either a read or a write.
    assign m0_req = m0_read | m0_write;
    assign m1_req = m1_read | m1_write;

    // Pick the winner this cycle. On a tie the port that did not win last time goes next. Nothing is granted while reset is held low.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = 1'b0;
        if (reset) begin
            if (m0_req && m1_req) begin
                gnt_valid = 1'b1;
                gnt_id    = ~last_gnt_q;
            end else if (m0_req) begin
                gnt_valid = 1'b1;
                gnt_id    = 1'b0;
            end else if (m1_req) begin
                gnt_valid = 1'b1;
                gnt_id    = 1'b1;
            end
        end
    end

    // If a port raises read and write together, the write wins and the read is dropped.
    always_comb begin
        gnt_write = 1'b0;
        if (gnt_valid) begin
            gnt_write = gnt_id ? m1_write : m0_write;
        end
        gnt_read = gnt_valid & ~gnt_write;
    end

    // Remember the last winner. Hold the value on cycles with no grant, so that fairness carries across idle gaps.
    always_comb begin
        last_gnt_d = last_gnt_q;
        if (gnt_valid) begin
            last_gnt_d = gnt_id;
        end
    end

    // The last-winner register resets to m1, so m0 takes the first tie after reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            last_gnt_q <= 1'b1;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end

    // Stall a requesting port that did not win. An idle port never sees waitrequest.
    always_comb begin
        m0_waitrequest = m0_req & ~(gnt_valid & ~gnt_id);
        m1_waitrequest = m1_req & ~(gnt_valid &  gnt_id);
    end

    // Steer the winning port onto the RAM. With no grant, the RAM bus is driven to zero.
    always_comb begin
        mem_chipselect = gnt_valid;
        mem_write      = gnt_write;
        mem_address    = '0;
        mem_byteenable = '0;
        mem_writedata  = '0;
        if (gnt_valid) begin
            if (gnt_id) begin
                mem_address    = m1_address;
                mem_byteenable = m1_byteenable;
                mem_writedata  = m1_writedata;
            end else begin
                mem_address    = m0_address;
                mem_byteenable = m0_byteenable;
                mem_writedata  = m0_writedata;
            end
        end
    end

    // The block never freezes the RAM clock.
    assign mem_clken = 1'b1;

    // Shift the {valid, owner} tag of each granted read along, one stage per cycle, to match the RAM's read latency.
    always_comb begin
        rd_valid_d    = rd_valid_q;
        rd_owner_d    = rd_owner_q;
        rd_valid_d[0] = gnt_read;
        rd_owner_d[0] = gnt_id;
        for (int i = 1; i < READ_LATENCY; i++) begin
            rd_valid_d[i] = rd_valid_q[i-1];
            rd_owner_d[i] = rd_owner_q[i-1];
        end
    end

    // Reset flushes the pipeline, so reads that were in flight are dropped and never return.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_valid_q <= '0;
            rd_owner_q <= '0;
        end else begin
            rd_valid_q <= rd_valid_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    // The last stage of the pipeline says which port owns the word the RAM is presenting now. Returns are masked while reset is low.
    always_comb begin
        ret_valid        = rd_valid_q[READ_LATENCY-1] & reset;
        ret_owner        = rd_owner_q[READ_LATENCY-1];
        m0_readdatavalid = ret_valid & ~ret_owner;
        m1_readdatavalid = ret_valid &  ret_owner;
        m0_readdata      = mem_readdata;
        m1_readdata      = mem_readdata;
    end

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Testbench for onchip_mem_arbiter.
// It uses two instances: `dut` built with READ_LATENCY=1 and `dut3` built with READ_LATENCY=3.
// Each instance is backed by a behavioural byte-enabled RAM that matches the configured latency.
// Inputs are driven 1 time unit after posedge and outputs are sampled on negedge.

module tb_onchip_mem_arbiter;

    logic clk;
    logic reset;

    logic [1:0]  m0_address, m1_address;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic [1:0]  mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect, mem_write, mem_clken;
    logic [31:0] mem_writedata, mem_readdata;

    logic [1:0]  l3_m0_address, l3_m1_address;
    logic [3:0]  l3_m0_byteenable, l3_m1_byteenable;
    logic        l3_m0_read, l3_m0_write, l3_m1_read, l3_m1_write;
    logic [31:0] l3_m0_writedata, l3_m1_writedata;
    logic        l3_m0_waitrequest, l3_m1_waitrequest;
    logic [31:0] l3_m0_readdata, l3_m1_readdata;
    logic        l3_m0_readdatavalid, l3_m1_readdatavalid;
    logic [1:0]  l3_mem_address;
    logic [3:0]  l3_mem_byteenable;
    logic        l3_mem_chipselect, l3_mem_write, l3_mem_clken;
    logic [31:0] l3_mem_writedata, l3_mem_readdata;

    int checks;
    int failures;

    onchip_mem_arbiter #(.ADDR_W(2), .DATA_W(32), .BE_W(4), .READ_LATENCY(1)) dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
        .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
        .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_clken(mem_clken), .mem_readdata(mem_readdata)
    );

    onchip_mem_arbiter #(.ADDR_W(2), .DATA_W(32), .BE_W(4), .READ_LATENCY(3)) dut3 (
        .clk(clk), .reset(reset),
        .m0_address(l3_m0_address), .m0_byteenable(l3_m0_byteenable), .m0_read(l3_m0_read),
        .m0_write(l3_m0_write), .m0_writedata(l3_m0_writedata), .m0_waitrequest(l3_m0_waitrequest),
        .m0_readdata(l3_m0_readdata), .m0_readdatavalid(l3_m0_readdatavalid),
        .m1_address(l3_m1_address), .m1_byteenable(l3_m1_byteenable), .m1_read(l3_m1_read),
        .m1_write(l3_m1_write), .m1_writedata(l3_m1_writedata), .m1_waitrequest(l3_m1_waitrequest),
        .m1_readdata(l3_m1_readdata), .m1_readdatavalid(l3_m1_readdatavalid),
        .mem_address(l3_mem_address), .mem_byteenable(l3_mem_byteenable),
        .mem_chipselect(l3_mem_chipselect), .mem_write(l3_mem_write),
        .mem_writedata(l3_mem_writedata), .mem_clken(l3_mem_clken), .mem_readdata(l3_mem_readdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAM with latency 1: address registered at the edge, q unregistered.
    logic [31:0] ram [4];
    logic [31:0] ram_q;
    always @(posedge clk) begin
        if (mem_chipselect) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
                end
            end else begin
                ram_q <= ram[mem_address];
            end
        end
    end
    assign mem_readdata = ram_q;

    // Same RAM with three cycles from address to q.
    logic [31:0] ram3 [4];
    logic [31:0] ram3_pipe [3];
    always @(posedge clk) begin
        if (l3_mem_chipselect && l3_mem_write) begin
            for (int b = 0; b < 4; b++) begin
                if (l3_mem_byteenable[b]) ram3[l3_mem_address][8*b +: 8] <= l3_mem_writedata[8*b +: 8];
            end
        end
        ram3_pipe[0] <= (l3_mem_chipselect && !l3_mem_write) ? ram3[l3_mem_address] : 32'h0;
        ram3_pipe[1] <= ram3_pipe[0];
        ram3_pipe[2] <= ram3_pipe[1];
    end
    assign l3_mem_readdata = ram3_pipe[2];

    task automatic clear_inputs();
        m0_address = 0; m0_byteenable = 0; m0_read = 0; m0_write = 0; m0_writedata = 0;
        m1_address = 0; m1_byteenable = 0; m1_read = 0; m1_write = 0; m1_writedata = 0;
        l3_m0_address = 0; l3_m0_byteenable = 0; l3_m0_read = 0; l3_m0_write = 0; l3_m0_writedata = 0;
        l3_m1_address = 0; l3_m1_byteenable = 0; l3_m1_read = 0; l3_m1_write = 0; l3_m1_writedata = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        next_cycle();
        reset = 1'b0;
        m0_read = 1'b1; m1_write = 1'b1; m1_byteenable = 4'hF;
        @(negedge clk);
        checks++; if (m0_waitrequest !== 1'b1) begin failures++; $display("[TB] FAIL rst_m0_wait got=%b exp=1", m0_waitrequest); end
        checks++; if (m1_waitrequest !== 1'b1) begin failures++; $display("[TB] FAIL rst_m1_wait got=%b exp=1", m1_waitrequest); end
        checks++; if (mem_chipselect !== 1'b0) begin failures++; $display("[TB] FAIL rst_cs got=%b exp=0", mem_chipselect); end
        checks++; if (mem_write !== 1'b0) begin failures++; $display("[TB] FAIL rst_write got=%b exp=0", mem_write); end
        checks++; if (mem_clken !== 1'b1) begin failures++; $display("[TB] FAIL rst_clken got=%b exp=1", mem_clken); end
        checks++; if (l3_mem_clken !== 1'b1) begin failures++; $display("[TB] FAIL rst_clken3 got=%b exp=1", l3_mem_clken); end
        next_cycle();
        @(negedge clk);
        checks++; if ({m0_readdatavalid, m1_readdatavalid} !== 2'b00) begin failures++; $display("[TB] FAIL rst_rdv got=%b exp=00", {m0_readdatavalid, m1_readdatavalid}); end
        next_cycle();
        reset = 1'b1;
        clear_inputs();
        @(negedge clk);
        checks++; if ({m0_waitrequest, m1_waitrequest, mem_chipselect} !== 3'b000) begin failures++; $display("[TB] FAIL idle_after_rst got=%b exp=000", {m0_waitrequest, m1_waitrequest, mem_chipselect}); end
    endtask

    task automatic test_write_read();
        next_cycle();
        m0_write = 1; m0_address = 2; m0_byteenable = 4'hF; m0_writedata = 32'hDEADBEEF;
        @(negedge clk);
        checks++; if (m0_waitrequest !== 1'b0) begin failures++; $display("[TB] FAIL wr_wait got=%b exp=0", m0_waitrequest); end
        checks++; if ({mem_chipselect, mem_write, mem_address} !== {1'b1, 1'b1, 2'd2}) begin failures++; $display("[TB] FAIL wr_mem got=%b exp=1110", {mem_chipselect, mem_write, mem_address}); end
        checks++; if (mem_writedata !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL wr_data got=%h exp=deadbeef", mem_writedata); end
        next_cycle();
        m0_write = 0; m0_read = 1;
        @(negedge clk);
        checks++; if (m0_waitrequest !== 1'b0) begin failures++; $display("[TB] FAIL rd_wait got=%b exp=0", m0_waitrequest); end
        checks++; if (m0_readdatavalid !== 1'b0) begin failures++; $display("[TB] FAIL wr_noresp got=%b exp=0", m0_readdatavalid); end
        next_cycle();
        clear_inputs();
        @(negedge clk);
        checks++; if (m0_readdatavalid !== 1'b1) begin failures++; $display("[TB] FAIL rd_rdv got=%b exp=1", m0_readdatavalid); end
        checks++; if (m0_readdata !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL rd_data got=%h exp=deadbeef", m0_readdata); end
        checks++; if (m1_readdatavalid !== 1'b0) begin failures++; $display("[TB] FAIL rd_m1_rdv got=%b exp=0", m1_readdatavalid); end
        next_cycle();
        @(negedge clk);
        checks++; if (m0_readdatavalid !== 1'b0) begin failures++; $display("[TB] FAIL rd_single got=%b exp=0", m0_readdatavalid); end
    endtask

    task automatic test_round_robin();
        int g;
        int owner;
        logic [31:0] exp_data;
        next_cycle();
        m0_write = 1; m0_address = 0; m0_byteenable = 4'hF; m0_writedata = 32'h11111111;
        next_cycle();
        clear_inputs();
        m1_write = 1; m1_address = 1; m1_byteenable = 4'hF; m1_writedata = 32'h22222222;
        next_cycle();
        clear_inputs();
        m0_read = 1; m0_address = 0; m1_read = 1; m1_address = 1;
        for (int c = 0; c < 7; c++) begin
            if (c == 6) begin
                next_cycle();
                clear_inputs();
            end else if (c > 0) begin
                next_cycle();
            end
            @(negedge clk);
            if (c < 6) begin
                g = c % 2;
                checks++; if (m0_waitrequest !== (g != 0)) begin failures++; $display("[TB] FAIL rr_m0_wait c=%0d got=%b exp=%b", c, m0_waitrequest, g != 0); end
                checks++; if (m1_waitrequest !== (g != 1)) begin failures++; $display("[TB] FAIL rr_m1_wait c=%0d got=%b exp=%b", c, m1_waitrequest, g != 1); end
                checks++; if (mem_address !== 2'(g)) begin failures++; $display("[TB] FAIL rr_addr c=%0d got=%0d exp=%0d", c, mem_address, g); end
            end
            if (c > 0) begin
                owner = (c - 1) % 2;
                exp_data = (owner == 1) ? 32'h22222222 : 32'h11111111;
                checks++; if ({m0_readdatavalid, m1_readdatavalid} !== {owner == 0, owner == 1}) begin failures++; $display("[TB] FAIL rr_rdv c=%0d got=%b exp=%b", c, {m0_readdatavalid, m1_readdatavalid}, {owner == 0, owner == 1}); end
                checks++; if ((owner == 0 ? m0_readdata : m1_readdata) !== exp_data) begin failures++; $display("[TB] FAIL rr_data c=%0d got=%h exp=%h", c, owner == 0 ? m0_readdata : m1_readdata, exp_data); end
            end
        end
    endtask

    task automatic test_byteenable();
        next_cycle();
        clear_inputs();
        m0_write = 1; m0_address = 3; m0_byteenable = 4'hF; m0_writedata = 32'h12345678;
        next_cycle();
        m0_byteenable = 4'h3; m0_writedata = 32'hAAAABBBB;
        @(negedge clk);
        checks++; if (mem_byteenable !== 4'h3) begin failures++; $display("[TB] FAIL be_lanes got=%h exp=3", mem_byteenable); end
        next_cycle();
        clear_inputs();
        m0_read = 1; m0_address = 3;
        next_cycle();
        clear_inputs();
        @(negedge clk);
        checks++; if (m0_readdatavalid !== 1'b1) begin failures++; $display("[TB] FAIL be_rdv got=%b exp=1", m0_readdatavalid); end
        checks++; if (m0_readdata !== 32'h1234BBBB) begin failures++; $display("[TB] FAIL be_data got=%h exp=1234bbbb", m0_readdata); end
    endtask

    task automatic test_conflict();
        next_cycle();
        clear_inputs();
        reset = 0;
        next_cycle();
        reset = 1;
        m0_write = 1; m0_address = 0; m0_byteenable = 4'hF; m0_writedata = 32'hCAFEF00D;
        m1_read = 1; m1_address = 0;
        @(negedge clk);
        checks++; if ({m0_waitrequest, m1_waitrequest, mem_write} !== 3'b011) begin failures++; $display("[TB] FAIL cf_first got=%b exp=011", {m0_waitrequest, m1_waitrequest, mem_write}); end
        next_cycle();
        m0_write = 0;
        @(negedge clk);
        checks++; if ({m1_waitrequest, mem_chipselect, mem_write} !== 3'b010) begin failures++; $display("[TB] FAIL cf_second got=%b exp=010", {m1_waitrequest, mem_chipselect, mem_write}); end
        next_cycle();
        clear_inputs();
        @(negedge clk);
        checks++; if ({m0_readdatavalid, m1_readdatavalid} !== 2'b01) begin failures++; $display("[TB] FAIL cf_rdv got=%b exp=01", {m0_readdatavalid, m1_readdatavalid}); end
        checks++; if (m1_readdata !== 32'hCAFEF00D) begin failures++; $display("[TB] FAIL cf_data got=%h exp=cafef00d", m1_readdata); end
    endtask

    task automatic test_reset_inflight();
        next_cycle();
        clear_inputs();
        m1_read = 1; m1_address = 1;
        @(negedge clk);
        checks++; if (m1_waitrequest !== 1'b0) begin failures++; $display("[TB] FAIL inf_grant got=%b exp=0", m1_waitrequest); end
        next_cycle();
        clear_inputs();
        reset = 0;
        @(negedge clk);
        checks++; if ({m0_readdatavalid, m1_readdatavalid} !== 2'b00) begin failures++; $display("[TB] FAIL inf_drop got=%b exp=00", {m0_readdatavalid, m1_readdatavalid}); end
        next_cycle();
        @(negedge clk);
        checks++; if ({m0_readdatavalid, m1_readdatavalid} !== 2'b00) begin failures++; $display("[TB] FAIL inf_drop2 got=%b exp=00", {m0_readdatavalid, m1_readdatavalid}); end
        next_cycle();
        reset = 1;
        m0_read = 1; m0_address = 0; m1_read = 1; m1_address = 1;
        @(negedge clk);
        checks++; if ({m0_waitrequest, m1_waitrequest} !== 2'b01) begin failures++; $display("[TB] FAIL inf_tie got=%b exp=01", {m0_waitrequest, m1_waitrequest}); end
        checks++; if ({m0_readdatavalid, m1_readdatavalid} !== 2'b00) begin failures++; $display("[TB] FAIL inf_post got=%b exp=00", {m0_readdatavalid, m1_readdatavalid}); end
        next_cycle();
        m0_read = 0;
        @(negedge clk);
        checks++; if ({m1_waitrequest, m0_readdatavalid} !== 2'b01) begin failures++; $display("[TB] FAIL inf_next got=%b exp=01", {m1_waitrequest, m0_readdatavalid}); end
        next_cycle();
        clear_inputs();
        @(negedge clk);
        checks++; if ({m0_readdatavalid, m1_readdatavalid} !== 2'b01) begin failures++; $display("[TB] FAIL inf_m1ret got=%b exp=01", {m0_readdatavalid, m1_readdatavalid}); end
    endtask

    task automatic test_latency3();
        logic [31:0] vals [4];
        for (int a = 0; a < 4; a++) begin
            vals[a] = $urandom;
            next_cycle();
            clear_inputs();
            l3_m1_write = 1; l3_m1_address = 2'(a); l3_m1_byteenable = 4'hF; l3_m1_writedata = vals[a];
        end
        for (int c = 0; c < 8; c++) begin
            next_cycle();
            clear_inputs();
            if (c < 4) begin
                l3_m1_read = 1; l3_m1_address = 2'(c);
            end
            @(negedge clk);
            checks++; if (l3_m1_waitrequest !== 1'b0) begin failures++; $display("[TB] FAIL l3_wait c=%0d got=%b exp=0", c, l3_m1_waitrequest); end
            checks++; if (l3_m1_readdatavalid !== (c >= 3 && c <= 6)) begin failures++; $display("[TB] FAIL l3_rdv c=%0d got=%b exp=%b", c, l3_m1_readdatavalid, c >= 3 && c <= 6); end
            checks++; if (l3_m0_readdatavalid !== 1'b0) begin failures++; $display("[TB] FAIL l3_m0_rdv c=%0d got=%b exp=0", c, l3_m0_readdatavalid); end
            if (c >= 3 && c <= 6) begin
                checks++; if (l3_m1_readdata !== vals[c-3]) begin failures++; $display("[TB] FAIL l3_data c=%0d got=%h exp=%h", c, l3_m1_readdata, vals[c-3]); end
            end
        end
    endtask

    typedef struct {
        int          due;
        int          port;
        logic [31:0] data;
    } ret_t;

    task automatic test_random();
        logic [31:0] ref_mem [4];
        ret_t        ret_q [$];
        logic        p_req [2];
        logic        p_wr [2];
        logic [1:0]  p_addr [2];
        logic [3:0]  p_be [2];
        logic [31:0] p_data [2];
        logic        hold [2];
        int          last;
        int          g;
        logic        exp_rdv [2];
        logic [31:0] exp_rd [2];
        int          kind;
        next_cycle();
        clear_inputs();
        reset = 0;
        next_cycle();
        reset = 1;
        last = 1;
        hold[0] = 0; hold[1] = 0;
        for (int a = 0; a < 4; a++) begin
            ref_mem[a] = $urandom;
            m0_write = 1; m0_address = 2'(a); m0_byteenable = 4'hF; m0_writedata = ref_mem[a];
            next_cycle();
        end
        clear_inputs();
        last = 0;
        for (int i = 0; i < 300; i++) begin
            next_cycle();
            for (int p = 0; p < 2; p++) begin
                if (!hold[p]) begin
                    p_req[p]  = ($urandom_range(0, 9) < 7);
                    kind      = $urandom_range(0, 2);
                    p_wr[p]   = p_req[p] && (kind != 0);
                    p_addr[p] = 2'($urandom_range(0, 3));
                    p_be[p]   = 4'($urandom_range(0, 15));
                    p_data[p] = $urandom;
                end
            end
            m0_read = p_req[0] && (!p_wr[0] || kind == 2); m0_write = p_wr[0];
            m0_address = p_addr[0]; m0_byteenable = p_be[0]; m0_writedata = p_data[0];
            m1_read = p_req[1] && !p_wr[1]; m1_write = p_wr[1];
            m1_address = p_addr[1]; m1_byteenable = p_be[1]; m1_writedata = p_data[1];
            @(negedge clk);
            g = -1;
            if (p_req[0] && p_req[1]) g = (last == 0) ? 1 : 0;
            else if (p_req[0]) g = 0;
            else if (p_req[1]) g = 1;
            checks++; if (m0_waitrequest !== (p_req[0] && g != 0)) begin failures++; $display("[TB] FAIL rnd_m0_wait i=%0d got=%b exp=%b", i, m0_waitrequest, p_req[0] && g != 0); end
            checks++; if (m1_waitrequest !== (p_req[1] && g != 1)) begin failures++; $display("[TB] FAIL rnd_m1_wait i=%0d got=%b exp=%b", i, m1_waitrequest, p_req[1] && g != 1); end
            checks++; if (mem_chipselect !== (g >= 0)) begin failures++; $display("[TB] FAIL rnd_cs i=%0d got=%b exp=%b", i, mem_chipselect, g >= 0); end
            if (g >= 0) begin
                checks++; if ({mem_write, mem_address} !== {p_wr[g], p_addr[g]}) begin failures++; $display("[TB] FAIL rnd_mem i=%0d got=%b exp=%b", i, {mem_write, mem_address}, {p_wr[g], p_addr[g]}); end
                if (p_wr[g]) begin
                    checks++; if ({mem_byteenable, mem_writedata} !== {p_be[g], p_data[g]}) begin failures++; $display("[TB] FAIL rnd_wdata i=%0d got=%h exp=%h", i, {mem_byteenable, mem_writedata}, {p_be[g], p_data[g]}); end
                end
            end else begin
                checks++; if ({mem_write, mem_address} !== 3'b000) begin failures++; $display("[TB] FAIL rnd_idle i=%0d got=%b exp=000", i, {mem_write, mem_address}); end
            end
            exp_rdv[0] = 0; exp_rdv[1] = 0; exp_rd[0] = 0; exp_rd[1] = 0;
            if (ret_q.size() > 0 && ret_q[0].due == i) begin
                exp_rdv[ret_q[0].port] = 1;
                exp_rd[ret_q[0].port]  = ret_q[0].data;
                void'(ret_q.pop_front());
            end
            checks++; if ({m0_readdatavalid, m1_readdatavalid} !== {exp_rdv[0], exp_rdv[1]}) begin failures++; $display("[TB] FAIL rnd_rdv i=%0d got=%b exp=%b", i, {m0_readdatavalid, m1_readdatavalid}, {exp_rdv[0], exp_rdv[1]}); end
            if (exp_rdv[0]) begin
                checks++; if (m0_readdata !== exp_rd[0]) begin failures++; $display("[TB] FAIL rnd_m0_data i=%0d got=%h exp=%h", i, m0_readdata, exp_rd[0]); end
            end
            if (exp_rdv[1]) begin
                checks++; if (m1_readdata !== exp_rd[1]) begin failures++; $display("[TB] FAIL rnd_m1_data i=%0d got=%h exp=%h", i, m1_readdata, exp_rd[1]); end
            end
            if (g >= 0) begin
                if (p_wr[g]) begin
                    for (int b = 0; b < 4; b++) begin
                        if (p_be[g][b]) ref_mem[p_addr[g]][8*b +: 8] = p_data[g][8*b +: 8];
                    end
                end else begin
                    ret_q.push_back('{i + 1, g, ref_mem[p_addr[g]]});
                end
                last = g;
            end
            hold[0] = p_req[0] && g != 0;
            hold[1] = p_req[1] && g != 1;
        end
        next_cycle();
        clear_inputs();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        clear_inputs();
        test_reset();
        test_write_read();
        test_round_robin();
        test_byteenable();
        test_conflict();
        test_reset_inflight();
        test_latency3();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
